tb_arp_reply_transmitter: RTL and testbench



---
 rtl/tb_arp_reply_transmitter.sv | 93 +++++++++
 tb/tb_tb_arp_reply_transmitter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tb_arp_reply_transmitter.sv
// ARP reply transmitter: on a fresh ARP request edge, latches a 60-byte reply frame
// and streams it as eight 64-bit AXI-Stream beats; overlapping requests are counted and dropped.
module tb_arp_reply_transmitter #(
  parameter logic [47:0] FPGA_MAC = 48'h211abcdef112,
  parameter logic [31:0] FPGA_IP  = 32'hC0000186
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_arp_valid,
  input  logic [47:0] i_SHA,
  input  logic [31:0] i_SPA,
  output logic        o_tx_axis_tvalid,
  input  logic        i_tx_axis_tready,
  output logic [63:0] o_tx_axis_tdata,
  output logic [7:0]  o_tx_axis_tkeep,
  output logic        o_tx_axis_tlast,
  output logic        o_busy,
  output logic        o_tx_done,
  output logic [7:0]  o_drop_cnt
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_nxt;
  logic         arp_d;
  logic [479:0] frame;
  logic [511:0] frame_pad;
  logic [2:0]   beat;
  logic         req, fire, last;

  assign req       = i_arp_valid & ~arp_d;
  assign fire      = o_tx_axis_tvalid & i_tx_axis_tready;
  assign last      = fire && (beat == 3'd7);
  // Beat 7 only carries bytes 56..59; the zero tail fills its unused lanes.
  assign frame_pad = {frame, 32'h0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req)  state_nxt = SEND;
      SEND:    if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      arp_d <= 1'b0;
    end else begin
      state <= state_nxt;
      arp_d <= i_arp_valid;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      frame <= '0;
      beat  <= '0;
    end else if (state == IDLE && req) begin
      frame <= {i_SHA, FPGA_MAC, 16'h0806,
                16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
                FPGA_MAC, FPGA_IP, i_SHA, i_SPA, 144'h0};
      beat  <= '0;
    end else if (fire) begin
      beat  <= beat + 3'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx_done  <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_tx_done <= last;
      // Requests during SEND (final handshake cycle included) are discarded.
      if (state == SEND && req && o_drop_cnt != 8'hFF)
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  always_comb begin
    o_tx_axis_tvalid = (state == SEND);
    o_busy           = (state == SEND);
    o_tx_axis_tdata  = '0;
    o_tx_axis_tkeep  = '0;
    o_tx_axis_tlast  = 1'b0;
    if (state == SEND) begin
      o_tx_axis_tdata = frame_pad[{~beat, 6'd0} +: 64];
      o_tx_axis_tkeep = (beat == 3'd7) ? 8'hF0 : 8'hFF;
      o_tx_axis_tlast = (beat == 3'd7);
    end
  end
endmodule

// File: tb/tb_tb_arp_reply_transmitter.sv
// Directed bench for the ARP reply transmitter: basic frame, backpressure,
// overlap drops, level hold, async reset mid-frame and drop-counter saturation.
module tb_tb_arp_reply_transmitter;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_arp_valid;
  logic [47:0] i_SHA;
  logic [31:0] i_SPA;
  logic        o_tx_axis_tvalid;
  logic        i_tx_axis_tready;
  logic [63:0] o_tx_axis_tdata;
  logic [7:0]  o_tx_axis_tkeep;
  logic        o_tx_axis_tlast;
  logic        o_busy;
  logic        o_tx_done;
  logic [7:0]  o_drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_beat [8] = '{
    64'h001122334455211A, 64'hBCDEF11208060001, 64'h080006040002211A,
    64'hBCDEF112C0000186, 64'h001122334455C0A8, 64'h0105000000000000,
    64'h0000000000000000, 64'h0000000000000000};

  tb_arp_reply_transmitter dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_arp_valid(i_arp_valid),
    .i_SHA(i_SHA), .i_SPA(i_SPA),
    .o_tx_axis_tvalid(o_tx_axis_tvalid), .i_tx_axis_tready(i_tx_axis_tready),
    .o_tx_axis_tdata(o_tx_axis_tdata), .o_tx_axis_tkeep(o_tx_axis_tkeep),
    .o_tx_axis_tlast(o_tx_axis_tlast), .o_busy(o_busy),
    .o_tx_done(o_tx_done), .o_drop_cnt(o_drop_cnt));

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called one cycle after the request edge was sampled. pulses<0 leaves
  // i_arp_valid untouched; otherwise it is lowered, then raised 'pulses' times.
  task automatic recv_frame(input string tag, input bit bp, input int pulses);
    int beat = 0;
    int cyc  = 0;
    int pl   = pulses;
    bit hi   = 1'b1;
    bit stalled = 1'b0;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    while (beat < 8 && cyc < 200) begin
      i_tx_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pulses >= 0) begin
        if (hi) begin
          i_arp_valid = 1'b0; hi = 1'b0;
        end else if (pl > 0) begin
          i_arp_valid = 1'b1; hi = 1'b1; pl--;
        end
      end
      @(negedge i_clk);
      check({tag, " tvalid"}, 64'(o_tx_axis_tvalid), 64'd1);
      check({tag, " busy"}, 64'(o_busy), 64'd1);
      if (stalled) begin
        check({tag, " stall tdata"}, o_tx_axis_tdata, hd);
        check({tag, " stall tkeep"}, 64'(o_tx_axis_tkeep), 64'(hk));
        check({tag, " stall tlast"}, 64'(o_tx_axis_tlast), 64'(hl));
      end
      if (i_tx_axis_tready) begin
        check($sformatf("%s beat%0d tdata", tag, beat), o_tx_axis_tdata, exp_beat[beat]);
        check($sformatf("%s beat%0d tkeep", tag, beat), 64'(o_tx_axis_tkeep),
              (beat == 7) ? 64'hF0 : 64'hFF);
        check($sformatf("%s beat%0d tlast", tag, beat), 64'(o_tx_axis_tlast),
              (beat == 7) ? 64'd1 : 64'd0);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        hd = o_tx_axis_tdata; hk = o_tx_axis_tkeep; hl = o_tx_axis_tlast;
      end
      tick();
      cyc++;
    end
    check({tag, " frame within budget"}, 64'(beat), 64'd8);
    check({tag, " tx_done pulse"}, 64'(o_tx_done), 64'd1);
    check({tag, " busy after"}, 64'(o_busy), 64'd0);
    check({tag, " tvalid after"}, 64'(o_tx_axis_tvalid), 64'd0);
    tick();
    check({tag, " tx_done one cycle"}, 64'(o_tx_done), 64'd0);
  endtask

  task automatic start_req();
    i_arp_valid = 1'b1;
    tick();
  endtask

  initial begin
    i_reset = 1'b1;
    i_arp_valid = 1'b0;
    i_SHA = 48'h001122334455;
    i_SPA = 32'hC0A80105;
    i_tx_axis_tready = 1'b1;
    #12;
    check("reset tvalid", 64'(o_tx_axis_tvalid), 64'd0);
    check("reset tdata", o_tx_axis_tdata, 64'd0);
    check("reset tkeep", 64'(o_tx_axis_tkeep), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset drop", 64'(o_drop_cnt), 64'd0);
    tick();
    i_reset = 1'b0;
    tick();

    // basic reply
    start_req();
    recv_frame("basic", 1'b0, 0);
    check("basic drop", 64'(o_drop_cnt), 64'd0);

    // backpressure
    start_req();
    recv_frame("bp", 1'b1, 0);
    check("bp drop", 64'(o_drop_cnt), 64'd0);

    // overlap: three edges inside one frame, then a fresh one afterwards
    start_req();
    recv_frame("ovl", 1'b0, 3);
    check("ovl drop", 64'(o_drop_cnt), 64'd3);
    check("ovl no second frame", 64'(o_tx_axis_tvalid), 64'd0);
    start_req();
    recv_frame("ovl2", 1'b0, 0);
    check("ovl2 drop", 64'(o_drop_cnt), 64'd3);

    // level held high for 20 cycles -> exactly one frame
    start_req();
    recv_frame("hold", 1'b0, -1);
    for (int i = 0; i < 10; i++) tick();
    check("hold no refire", 64'(o_tx_axis_tvalid), 64'd0);
    check("hold drop", 64'(o_drop_cnt), 64'd3);
    i_arp_valid = 1'b0;
    tick();

    // async reset during beat 3
    start_req();
    i_arp_valid = 1'b0;
    tick(); tick(); tick();
    check("rst beat3 tdata", o_tx_axis_tdata, exp_beat[3]);
    #2;
    i_reset = 1'b1;
    #1;
    check("rst tvalid", 64'(o_tx_axis_tvalid), 64'd0);
    check("rst tdata", o_tx_axis_tdata, 64'd0);
    check("rst tkeep", 64'(o_tx_axis_tkeep), 64'd0);
    check("rst tlast", 64'(o_tx_axis_tlast), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst done", 64'(o_tx_done), 64'd0);
    check("rst drop", 64'(o_drop_cnt), 64'd0);
    tick();
    i_reset = 1'b0;
    i_arp_valid = 1'b1;
    tick();
    recv_frame("post-rst", 1'b0, -1);
    i_arp_valid = 1'b0;
    tick();

    // saturation: 300 edges while the frame is stalled on beat 0
    i_tx_axis_tready = 1'b0;
    start_req();
    for (int i = 0; i < 300; i++) begin
      i_arp_valid = 1'b0;
      tick();
      i_arp_valid = 1'b1;
      tick();
      if (i == 99) check("sat drop 100", 64'(o_drop_cnt), 64'd100);
    end
    i_arp_valid = 1'b0;
    tick();
    check("sat drop", 64'(o_drop_cnt), 64'hFF);
    check("sat stalled tvalid", 64'(o_tx_axis_tvalid), 64'd1);
    check("sat stalled tdata", o_tx_axis_tdata, exp_beat[0]);
    recv_frame("sat drain", 1'b0, -1);
    check("sat drop after", 64'(o_drop_cnt), 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
